spi_slave_ctrl: RTL and testbench

- Serial front-end and sequencer for the single-port SPI RAM block. It deserialises 10-bit MOSI frames into parallel rx_data/rx_valid words and tracks the write/read command sequence.
- On a read-data command it captures the RAM's tx_data/tx_valid reply and shifts it out on MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper. clk is the SPI serial clock.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_shift_out.sv | 48 ++++
 rtl/spi_slave_ctrl.sv | 100 ++++++++++
 tb/tb_spi_slave_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller and its serialiser.
package spi_pkg;
  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
endpackage

// File: rtl/spi_shift_out.sv
// Load/shift serialiser: emits a DATA_W-bit word MSB first on a registered output.
module spi_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_miso, r_busy, r_done;

  // The MSB goes out on the load edge itself, so only DATA_W-1 shifts follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0; r_cnt <= '0; r_miso <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
    end else if (i_clr) begin
      r_sh <= '0; r_cnt <= '0; r_miso <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
    end else if (i_load) begin
      r_sh   <= {i_data[DATA_W-2:0], 1'b0};
      r_miso <= i_data[DATA_W-1];
      r_cnt  <= CW'(DATA_W - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_miso <= r_sh[DATA_W-1];
        r_sh   <= {r_sh[DATA_W-2:0], 1'b0};
        r_cnt  <= r_cnt - 1'b1;
      end else begin
        r_miso <= 1'b0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises MOSI frames for the RAM and returns read data on MISO.
module spi_slave_ctrl import spi_pkg::*; #(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);
  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);

  state_e             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [FRAME_W-2:0] r_sh;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid, r_rd_addr_done;
  logic               w_load, w_busy, w_done, w_frame_done;

  assign w_frame_done = (r_cnt == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE:      if (!ss_n) w_next = CHK_CMD;
      CHK_CMD: begin
        if (mosi != CMD_RD_ADDR[1]) w_next = WRITE;
        else if (r_rd_addr_done)    w_next = READ_DATA;
        else                        w_next = READ_ADD;
      end
      READ_DATA: w_load = w_frame_done && !(w_busy || w_done) && tx_valid;
      default: ;
    endcase
    if (ss_n) begin
      w_next = IDLE;
      w_load = 1'b0;
    end
  end

  // The command bit is captured in CHK_CMD, so the receive shifter only holds FRAME_W-1 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_sh <= '0; r_rx_data <= '0; r_rx_valid <= 1'b0; r_rd_addr_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (ss_n) begin
        r_cnt <= '0;
        r_sh  <= '0;
      end else begin
        case (r_state)
          CHK_CMD: begin
            r_sh  <= {{(FRAME_W-2){1'b0}}, mosi};
            r_cnt <= CW'(1);
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!w_frame_done) begin
              r_sh  <= {r_sh[FRAME_W-3:0], mosi};
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == CNT_LAST) begin
                r_rx_data  <= {r_sh, mosi};
                r_rx_valid <= 1'b1;
                if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
              end
            end else if (w_load) begin
              r_rd_addr_done <= 1'b0;
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  spi_shift_out #(.DATA_W(DATA_W)) u_shift_out (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_clr  (ss_n),
    .i_data (tx_data),
    .o_miso (miso),
    .o_busy (w_busy),
    .o_done (w_done)
  );

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: frame table, read replies, aborts and async reset.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, ss_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, rx_valid;
  logic [9:0] rx_data;

  int checks = 0, errors = 0;
  logic [9:0] rx_q[$];
  logic       miso_q[$];

  typedef struct {
    logic [9:0] frame;
    state_e     st;
    logic       rdad;
  } vec_t;
  vec_t vt[6];

  spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // rx scoreboard: every rx_valid pulse must match the next queued frame
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got rx_data %0h with nothing expected at %0t", rx_data, $time);
      end else begin
        logic [9:0] e;
        e = rx_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got %0h expected %0h at %0t", rx_data, e, $time);
        end
      end
    end
  end

  task automatic do_reset;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drops ss_n, then drives the top n bits of f; returns on the negedge after the last bit.
  task automatic send_bits(input logic [9:0] f, input int n);
    ss_n = 1'b0;
    @(negedge clk);
    for (int i = 9; i > 9 - n; i--) begin
      mosi = f[i];
      @(negedge clk);
      if (i != 9 - n + 1) chk("miso_rx", 32'(miso), 32'(0));
    end
  endtask

  task automatic send_frame(input logic [9:0] f);
    rx_q.push_back(f);
    send_bits(f, 10);
  endtask

  task automatic end_frame;
    ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
  endtask

  // Called on the negedge where rx_valid of a read-data frame is high.
  task automatic read_reply(input int delay, input logic [7:0] d);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("miso_wait", 32'(miso), 32'(0));
    end
    tx_data = d; tx_valid = 1'b1;
    for (int b = 7; b >= 0; b--) miso_q.push_back(d[b]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk("miso_bit", 32'(miso), 32'(miso_q.pop_front()));
    end
    @(negedge clk);
    chk("miso_after", 32'(miso), 32'(0));
    chk("rdad_clr", 32'(dut.r_rd_addr_done), 32'(0));
    tx_data = ~d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("miso_stray", 32'(miso), 32'(0));
  endtask

  task automatic set_rd_addr(input logic [9:0] f);
    send_frame(f);
    end_frame;
    chk("rdad_set", 32'(dut.r_rd_addr_done), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0] = '{10'b00_1010_0101, WRITE,     1'b0};
    vt[1] = '{10'b01_0011_1100, WRITE,     1'b0};
    vt[2] = '{10'b10_0000_0011, READ_ADD,  1'b1};
    vt[3] = '{10'b01_1111_1111, WRITE,     1'b1};
    vt[4] = '{10'b11_0000_0001, READ_DATA, 1'b1};
    vt[5] = '{10'b00_0000_0000, WRITE,     1'b1};

    #1;
    chk("rst_miso", 32'(miso), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_rdad", 32'(dut.r_rd_addr_done), 32'(0));
    do_reset;

    foreach (vt[i]) begin
      send_frame(vt[i].frame);
      chk("tbl_state", 32'(dut.r_state), 32'(vt[i].st));
      chk("tbl_miso", 32'(miso), 32'(0));
      end_frame;
      chk("tbl_idle", 32'(dut.r_state), 32'(IDLE));
      chk("tbl_rdad", 32'(dut.r_rd_addr_done), 32'(vt[i].rdad));
      chk("tbl_hold", 32'(rx_data), 32'(vt[i].frame));
    end

    // read address then read data with a one-cycle RAM
    do_reset;
    set_rd_addr(10'b10_0000_0011);
    send_frame({CMD_RD_DATA, 8'h00});
    chk("rd_state", 32'(dut.r_state), 32'(READ_DATA));
    read_reply(1, 8'hC3);
    end_frame;
    chk("rd_idle", 32'(dut.r_state), 32'(IDLE));

    // read-data command without a prior address goes to READ_ADD
    do_reset;
    send_frame(10'b11_0101_0101);
    chk("rd_noaddr_state", 32'(dut.r_state), 32'(READ_ADD));
    end_frame;
    chk("rd_noaddr_rdad", 32'(dut.r_rd_addr_done), 32'(1));

    // abort after 6 bits
    do_reset;
    send_bits(10'b10_1100_0000, 6);
    ss_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(dut.r_state), 32'(IDLE));
    chk("abort_rdad", 32'(dut.r_rd_addr_done), 32'(0));
    send_frame(10'b01_1111_0000);
    end_frame;
    chk("abort_next", 32'(rx_data), 32'h1F0);

    // late tx_valid: three-cycle wait before the reply
    do_reset;
    set_rd_addr({CMD_RD_ADDR, 8'h44});
    send_frame({CMD_RD_DATA, 8'h44});
    read_reply(3, 8'h5A);
    end_frame;

    // stray tx_valid throughout a write frame
    do_reset;
    tx_data = 8'hFF; tx_valid = 1'b1;
    send_frame({CMD_WR_DATA, 8'h81});
    @(negedge clk);
    chk("stray_miso", 32'(miso), 32'(0));
    chk("stray_state", 32'(dut.r_state), 32'(WRITE));
    tx_valid = 1'b0;
    end_frame;

    // async reset on the rx_valid cycle of a read-address frame
    do_reset;
    send_frame({CMD_RD_ADDR, 8'h12});
    #2 rst = 1'b1;
    #1;
    chk("arst_rx_valid", 32'(rx_valid), 32'(0));
    chk("arst_rdad", 32'(dut.r_rd_addr_done), 32'(0));
    chk("arst_state", 32'(dut.r_state), 32'(IDLE));
    chk("arst_rx_data", 32'(rx_data), 32'(0));
    do_reset;

    // async reset during the 4th reply bit
    set_rd_addr({CMD_RD_ADDR, 8'h07});
    send_frame({CMD_RD_DATA, 8'h07});
    @(negedge clk);
    tx_data = 8'hFF; tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk("arst_pre_bit", 32'(miso), 32'(1));
    end
    #2 rst = 1'b1;
    #1;
    chk("arst2_miso", 32'(miso), 32'(0));
    chk("arst2_rx_valid", 32'(rx_valid), 32'(0));
    chk("arst2_state", 32'(dut.r_state), 32'(IDLE));
    chk("arst2_rdad", 32'(dut.r_rd_addr_done), 32'(0));
    do_reset;
    ss_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst2_quiet", 32'(miso), 32'(0));
    end_frame;

    chk("rx_q_empty", 32'(rx_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
